// File: rtl/fc_class_collect_if.sv
// Stream-in (FC words) and result-out handshakes of the FC class collector.
interface fc_class_collect_if #(
   parameter int DATA_W = 16
);
   logic              fc_valid;
   logic              fc_ready;
   logic [DATA_W-1:0] fc_data;
   logic              fc_last;
   logic              res_valid;
   logic              res_ready;
   logic [3:0]        res_index;
   logic [DATA_W-1:0] res_value;

   modport master (
      output fc_valid, fc_data, fc_last, res_ready,
      input  fc_ready, res_valid, res_index, res_value
   );

   modport slave (
      input  fc_valid, fc_data, fc_last, res_ready,
      output fc_ready, res_valid, res_index, res_value
   );
endinterface

// File: rtl/fc_class_collect.sv
// Collects one frame of FC scores, launches get_class, and hands the winner downstream.
// Optional FC_SIGNED_SCORE_EN: two's complement scores mapped to offset binary for get_class.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   S_COLLECT | accepting FC words into class0..9, fc_ready high
//   S_LAUNCH  | one-cycle get_class_start, watchdog loaded
//   S_WAIT    | class regs held, waiting for get_class_done or watchdog
//   S_RESULT  | res_valid high until downstream takes the result
module fc_class_collect #(
   parameter int DATA_W    = 16,
   parameter int NUM_CLASS = 10,
   parameter int WAIT_MAX  = 15
) (
   input  logic              clk,
   input  logic              rst,
   fc_class_collect_if.slave bus,
   output logic [DATA_W-1:0] class0,
   output logic [DATA_W-1:0] class1,
   output logic [DATA_W-1:0] class2,
   output logic [DATA_W-1:0] class3,
   output logic [DATA_W-1:0] class4,
   output logic [DATA_W-1:0] class5,
   output logic [DATA_W-1:0] class6,
   output logic [DATA_W-1:0] class7,
   output logic [DATA_W-1:0] class8,
   output logic [DATA_W-1:0] class9,
   output logic              get_class_start,
   input  logic              get_class_done,
   input  logic [DATA_W-1:0] class_value,
   input  logic [3:0]        class_index,
   output logic              frame_err
);

   localparam int         TMR_W    = $clog2(WAIT_MAX + 1);
   localparam logic [3:0] LAST_CNT = 4'(NUM_CLASS - 1);

`ifdef FC_SIGNED_SCORE_EN
   localparam logic [DATA_W-1:0] SCORE_FLIP = {1'b1, {(DATA_W-1){1'b0}}};
`else
   localparam logic [DATA_W-1:0] SCORE_FLIP = '0;
`endif

   typedef enum logic [1:0] {
      S_COLLECT = 2'd0,
      S_LAUNCH  = 2'd1,
      S_WAIT    = 2'd2,
      S_RESULT  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [TMR_W-1:0]  tmr_q, tmr_d;
   logic [DATA_W-1:0] class_q [NUM_CLASS];
   logic [DATA_W-1:0] class_d [NUM_CLASS];
   logic [3:0]        res_index_q, res_index_d;
   logic [DATA_W-1:0] res_value_q, res_value_d;
   logic              frame_err_q, frame_err_d;

   logic beat;
   logic beat_end;
   logic beat_bad;
   logic tmr_done;

   assign beat     = bus.fc_valid & bus.fc_ready;
   assign beat_end = (cnt_q == LAST_CNT);
   // fc_last must coincide exactly with the final slot; any disagreement is a framing error
   assign beat_bad = beat & (bus.fc_last ^ beat_end);
   assign tmr_done = (tmr_q == '0);

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_COLLECT;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_COLLECT: if (beat && bus.fc_last && beat_end) state_d = S_LAUNCH;
         S_LAUNCH:  state_d = S_WAIT;
         S_WAIT: begin
            if (tmr_done)            state_d = S_COLLECT;
            else if (get_class_done) state_d = S_RESULT;
         end
         S_RESULT:  if (bus.res_ready) state_d = S_COLLECT;
         default:   state_d = S_COLLECT;
      endcase
   end

   always_comb begin
      bus.fc_ready    = (state_q == S_COLLECT) && !rst;
      get_class_start = (state_q == S_LAUNCH) && !rst;
      bus.res_valid   = (state_q == S_RESULT) && !rst;
   end

   always_comb begin
      cnt_d       = cnt_q;
      tmr_d       = tmr_q;
      class_d     = class_q;
      res_index_d = res_index_q;
      res_value_d = res_value_q;
      frame_err_d = 1'b0;
      case (state_q)
         S_COLLECT: begin
            if (beat) begin
               for (int i = 0; i < NUM_CLASS; i++) begin
                  if (cnt_q == 4'(i)) class_d[i] = bus.fc_data ^ SCORE_FLIP;
               end
               cnt_d       = (beat_end || bus.fc_last) ? 4'd0 : cnt_q + 4'd1;
               frame_err_d = beat_bad;
            end
         end
         S_LAUNCH: tmr_d = TMR_W'(WAIT_MAX - 1);
         S_WAIT: begin
            // error flagged one cycle before the abort so fc_ready rises right after the pulse
            if (!tmr_done) begin
               tmr_d = tmr_q - TMR_W'(1);
               if (get_class_done) begin
                  res_index_d = class_index;
                  res_value_d = class_value ^ SCORE_FLIP;
               end else begin
                  frame_err_d = (tmr_q == TMR_W'(1));
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         tmr_q       <= '0;
         res_index_q <= '0;
         res_value_q <= '0;
         frame_err_q <= 1'b0;
         for (int i = 0; i < NUM_CLASS; i++) class_q[i] <= '0;
      end else begin
         cnt_q       <= cnt_d;
         tmr_q       <= tmr_d;
         res_index_q <= res_index_d;
         res_value_q <= res_value_d;
         frame_err_q <= frame_err_d;
         class_q     <= class_d;
      end
   end

   assign class0        = class_q[0];
   assign class1        = class_q[1];
   assign class2        = class_q[2];
   assign class3        = class_q[3];
   assign class4        = class_q[4];
   assign class5        = class_q[5];
   assign class6        = class_q[6];
   assign class7        = class_q[7];
   assign class8        = class_q[8];
   assign class9        = class_q[9];
   assign bus.res_index = res_index_q;
   assign bus.res_value = res_value_q;
   assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_fc_class_collect.sv
// Self-checking bench for fc_class_collect with a behavioural get_class stand-in.
module tb_fc_class_collect;
   localparam int DW       = 16;
   localparam int WAIT_MAX = 15;

   typedef logic [DW-1:0] frame_t [10];

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fc_class_collect_if #(.DATA_W(DW)) bus ();

   logic [DW-1:0] c0, c1, c2, c3, c4, c5, c6, c7, c8, c9;
   logic [DW-1:0] cls [10];
   logic          get_class_start, get_class_done, frame_err;
   logic [DW-1:0] class_value;
   logic [3:0]    class_index;
   logic [3:0]    gc_pipe;
   logic          gc_en;

   int checks   = 0;
   int failures = 0;

   fc_class_collect #(.DATA_W(DW), .NUM_CLASS(10), .WAIT_MAX(WAIT_MAX)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .class0(c0), .class1(c1), .class2(c2), .class3(c3), .class4(c4),
      .class5(c5), .class6(c6), .class7(c7), .class8(c8), .class9(c9),
      .get_class_start(get_class_start), .get_class_done(get_class_done),
      .class_value(class_value), .class_index(class_index), .frame_err(frame_err)
   );

   always_comb begin
      cls[0] = c0; cls[1] = c1; cls[2] = c2; cls[3] = c3; cls[4] = c4;
      cls[5] = c5; cls[6] = c6; cls[7] = c7; cls[8] = c8; cls[9] = c9;
   end

   // get_class stand-in: 4-cycle start-to-done, unsigned argmax, ties to higher index
   always @(posedge clk) begin
      if (rst) gc_pipe <= '0;
      else     gc_pipe <= {gc_pipe[2:0], get_class_start};
   end
   assign get_class_done = gc_pipe[3] & gc_en;

   always_comb begin
      logic [3:0]    bi;
      logic [DW-1:0] bv;
      bi = 4'd0;
      bv = cls[0];
      for (int i = 1; i < 10; i++) begin
         if (cls[i] >= bv) begin
            bv = cls[i];
            bi = 4'(i);
         end
      end
      class_index = bi;
      class_value = bv;
   end

   // reference model: rank by numeric score value
   function automatic int score_of(input logic [DW-1:0] w);
`ifdef FC_SIGNED_SCORE_EN
      return int'($signed(w));
`else
      return int'(w);
`endif
   endfunction

   function automatic logic [DW-1:0] exp_class(input logic [DW-1:0] w);
`ifdef FC_SIGNED_SCORE_EN
      return 16'(int'($signed(w)) + 32768);
`else
      return w;
`endif
   endfunction

   task automatic ref_result(input frame_t w, output logic [3:0] idx, output logic [DW-1:0] val);
      int best;
      best = 0;
      for (int i = 1; i < 10; i++) if (score_of(w[i]) >= score_of(w[best])) best = i;
      idx = 4'(best);
      val = w[best];
   endtask

   task automatic send_beats(input frame_t w, input int n, input int last_pos);
      for (int i = 0; i < n; i++) begin
         int guard;
         @(negedge clk);
         bus.fc_valid = 1'b1;
         bus.fc_data  = w[i];
         bus.fc_last  = (i == last_pos);
         guard = 0;
         while (!bus.fc_ready && guard < 100) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 100) begin
            checks++; failures++;
            $display("FAIL send_beats: fc_ready=%b after %0d cycles, required 1", bus.fc_ready, guard);
         end
         @(posedge clk);
      end
      @(negedge clk);
      bus.fc_valid = 1'b0;
      bus.fc_last  = 1'b0;
   endtask

   // n counts negedges after the last beat edge; n=1 is the current negedge
   task automatic wait_result(input bit stop_at_valid, output int n_start, output int n_valid,
                              output int n_ready, output int n_err, output logic [3:0] idx,
                              output logic [DW-1:0] val, output frame_t snap);
      n_start = -1; n_valid = -1; n_ready = -1; n_err = -1;
      idx = '0; val = '0; snap = cls;
      for (int n = 1; n <= 60; n++) begin
         if (n > 1) @(negedge clk);
         if (get_class_start && n_start < 0) n_start = n;
         if (frame_err && n_err < 0) n_err = n;
         if (bus.res_valid && n_valid < 0) begin
            n_valid = n; idx = bus.res_index; val = bus.res_value; snap = cls;
            if (stop_at_valid) break;
         end
         if (n_valid >= 0 && bus.fc_ready && n_ready < 0) begin
            n_ready = n;
            break;
         end
      end
   endtask

   task automatic check_frame(input string tag, input frame_t w, input bit stop_at_valid);
      int n_s, n_v, n_r, n_e, bad;
      logic [3:0] idx, e_idx;
      logic [DW-1:0] val, e_val;
      frame_t snap;
      ref_result(w, e_idx, e_val);
      send_beats(w, 10, 9);
      wait_result(stop_at_valid, n_s, n_v, n_r, n_e, idx, val, snap);
      checks++; if (n_s !== 1) begin failures++; $display("FAIL %s start_latency: got %0d required 1", tag, n_s); end
      checks++; if (n_v !== 6) begin failures++; $display("FAIL %s valid_latency: got %0d required 6", tag, n_v); end
      if (!stop_at_valid) begin
         checks++; if (n_r !== 7) begin failures++; $display("FAIL %s ready_latency: got %0d required 7", tag, n_r); end
      end
      checks++; if (idx !== e_idx) begin failures++; $display("FAIL %s res_index: got %0d required %0d", tag, idx, e_idx); end
      checks++; if (val !== e_val) begin failures++; $display("FAIL %s res_value: got %h required %h", tag, val, e_val); end
      checks++; if (n_e !== -1) begin failures++; $display("FAIL %s spurious_frame_err: got pulse at %0d required none", tag, n_e); end
      bad = 0;
      for (int i = 0; i < 10; i++) if (snap[i] !== exp_class(w[i])) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL %s class_regs: %0d mismatching, class0=%h required %h", tag, bad, snap[0], exp_class(w[0])); end
   endtask

   task automatic test_reset();
      int bad;
      rst = 1'b1; bus.fc_valid = 1'b0; bus.fc_last = 1'b0; bus.fc_data = '0;
      bus.res_ready = 1'b1; gc_en = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (bus.fc_ready !== 1'b0) begin failures++; $display("FAIL reset_fc_ready: got %b required 0", bus.fc_ready); end
      checks++; if (get_class_start !== 1'b0) begin failures++; $display("FAIL reset_start: got %b required 0", get_class_start); end
      checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL reset_res_valid: got %b required 0", bus.res_valid); end
      checks++; if (bus.res_index !== 4'd0 || bus.res_value !== 16'd0) begin failures++; $display("FAIL reset_result: got %0d/%h required 0/0000", bus.res_index, bus.res_value); end
      checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b required 0", frame_err); end
      bad = 0;
      for (int i = 0; i < 10; i++) if (cls[i] !== 16'd0) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL reset_class_regs: %0d nonzero required 0", bad); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (bus.fc_ready !== 1'b1) begin failures++; $display("FAIL post_reset_fc_ready: got %b required 1", bus.fc_ready); end
   endtask

   task automatic test_latency();
      frame_t w;
      for (int i = 0; i < 10; i++) w[i] = 16'(100 * (i + 1));
      bus.res_ready = 1'b1;
      check_frame("ramp", w, 1'b0);
   endtask

   task automatic test_equal();
      frame_t w;
      for (int i = 0; i < 10; i++) w[i] = 16'h0050;
      check_frame("ties", w, 1'b0);
   endtask

   task automatic test_framing();
      frame_t w;
      int starts, errs;
      for (int i = 0; i < 10; i++) w[i] = 16'($urandom);
      send_beats(w, 5, 4);
      checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL early_last_frame_err: got %b required 1", frame_err); end
      starts = 0; errs = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (get_class_start) starts++;
         if (frame_err) errs++;
      end
      checks++; if (starts != 0) begin failures++; $display("FAIL early_last_no_start: got %0d starts required 0", starts); end
      checks++; if (errs != 0) begin failures++; $display("FAIL early_last_pulse_width: got %0d extra cycles required 0", errs); end
      checks++; if (bus.fc_ready !== 1'b1) begin failures++; $display("FAIL early_last_fc_ready: got %b required 1", bus.fc_ready); end
      send_beats(w, 10, -1);
      checks++; if (frame_err !== 1'b1) begin failures++; $display("FAIL missing_last_frame_err: got %b required 1", frame_err); end
      for (int i = 0; i < 10; i++) w[i] = 16'($urandom_range(0, 16'h02FF));
      w[4] = 16'h0300;
      check_frame("after_err", w, 1'b0);
   endtask

   task automatic test_backpressure();
      frame_t w, snap;
      int n_s, n_v, n_r, n_e, bad;
      logic [3:0] idx, e_idx;
      logic [DW-1:0] val, e_val;
      for (int i = 0; i < 10; i++) w[i] = 16'($urandom);
      ref_result(w, e_idx, e_val);
      bus.res_ready = 1'b0;
      send_beats(w, 10, 9);
      wait_result(1'b1, n_s, n_v, n_r, n_e, idx, val, snap);
      checks++; if (n_v !== 6) begin failures++; $display("FAIL bp_valid_latency: got %0d required 6", n_v); end
      bad = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (bus.res_valid !== 1'b1 || bus.res_index !== e_idx || bus.res_value !== e_val) bad++;
         if (bus.fc_ready !== 1'b0) bad++;
         for (int i = 0; i < 10; i++) if (cls[i] !== exp_class(w[i])) bad++;
      end
      checks++; if (bad != 0) begin failures++; $display("FAIL bp_hold: got %0d violations required 0 (index %0d value %h)", bad, bus.res_index, bus.res_value); end
      bus.res_ready = 1'b1;
      @(negedge clk);
      checks++; if (bus.res_valid !== 1'b0) begin failures++; $display("FAIL bp_release_valid: got %b required 0", bus.res_valid); end
      checks++; if (bus.fc_ready !== 1'b1) begin failures++; $display("FAIL bp_release_fc_ready: got %b required 1", bus.fc_ready); end
   endtask

   task automatic test_signed_ranking();
      frame_t w, snap;
      int n_s, n_v, n_r, n_e;
      logic [3:0] idx, e_idx;
      logic [DW-1:0] val, e_val;
      for (int i = 0; i < 10; i++) w[i] = 16'h8000;
      w[2] = 16'h0005;
      w[7] = 16'hFFF0;
`ifdef FC_SIGNED_SCORE_EN
      e_idx = 4'd2; e_val = 16'h0005;
`else
      e_idx = 4'd7; e_val = 16'hFFF0;
`endif
      send_beats(w, 10, 9);
      wait_result(1'b0, n_s, n_v, n_r, n_e, idx, val, snap);
      checks++; if (idx !== e_idx) begin failures++; $display("FAIL signed_index: got %0d required %0d", idx, e_idx); end
      checks++; if (val !== e_val) begin failures++; $display("FAIL signed_value: got %h required %h", val, e_val); end
   endtask

   task automatic test_random();
      frame_t w, snap;
      int n_s, n_v, n_r, n_e, hold, bad;
      logic [3:0] idx, e_idx;
      logic [DW-1:0] val, e_val;
      for (int f = 0; f < 25; f++) begin
         for (int i = 0; i < 10; i++)
            w[i] = ($urandom_range(0, 3) == 0) ? 16'h0040 : 16'($urandom);
         if ($urandom_range(0, 1) == 1) begin
            bus.res_ready = 1'b1;
            check_frame("random", w, 1'b0);
         end else begin
            ref_result(w, e_idx, e_val);
            bus.res_ready = 1'b0;
            send_beats(w, 10, 9);
            wait_result(1'b1, n_s, n_v, n_r, n_e, idx, val, snap);
            checks++; if (idx !== e_idx || val !== e_val) begin failures++; $display("FAIL random_bp_result: got %0d/%h required %0d/%h", idx, val, e_idx, e_val); end
            hold = $urandom_range(1, 6);
            bad = 0;
            for (int k = 0; k < hold; k++) begin
               @(negedge clk);
               if (bus.res_valid !== 1'b1 || bus.fc_ready !== 1'b0) bad++;
            end
            checks++; if (bad != 0) begin failures++; $display("FAIL random_bp_hold: got %0d violations required 0", bad); end
            bus.res_ready = 1'b1;
            @(negedge clk);
            checks++; if (bus.fc_ready !== 1'b1 || bus.res_valid !== 1'b0) begin failures++; $display("FAIL random_bp_release: got ready=%b valid=%b required 1/0", bus.fc_ready, bus.res_valid); end
         end
      end
   endtask

   task automatic test_watchdog();
      frame_t w;
      logic rdy [64];
      int n_s, n_e, errs, valids;
      for (int i = 0; i < 10; i++) w[i] = 16'($urandom);
      gc_en = 1'b0;
      send_beats(w, 10, 9);
      n_s = -1; n_e = -1; errs = 0; valids = 0;
      for (int n = 1; n < 64; n++) begin
         if (n > 1) @(negedge clk);
         rdy[n] = bus.fc_ready;
         if (get_class_start && n_s < 0) n_s = n;
         if (frame_err) begin errs++; if (n_e < 0) n_e = n; end
         if (bus.res_valid) valids++;
      end
      checks++; if (n_s !== 1) begin failures++; $display("FAIL wd_start: got %0d required 1", n_s); end
      checks++; if (n_e - n_s !== WAIT_MAX) begin failures++; $display("FAIL wd_abort_time: got %0d cycles required %0d", n_e - n_s, WAIT_MAX); end
      checks++; if (errs != 1) begin failures++; $display("FAIL wd_pulse_count: got %0d required 1", errs); end
      checks++; if (valids != 0) begin failures++; $display("FAIL wd_no_result: got %0d valid cycles required 0", valids); end
      if (n_e > 0 && n_e < 62) begin
         checks++; if (rdy[n_e] !== 1'b0) begin failures++; $display("FAIL wd_ready_at_err: got %b required 0", rdy[n_e]); end
         checks++; if (rdy[n_e + 1] !== 1'b1) begin failures++; $display("FAIL wd_ready_after_err: got %b required 1", rdy[n_e + 1]); end
      end
      gc_en = 1'b1;
   endtask

   task automatic test_reset_in_wait();
      frame_t w;
      int bad, errs, valids, starts;
      for (int i = 0; i < 10; i++) w[i] = 16'($urandom) | 16'h0001;
      gc_en = 1'b0;
      send_beats(w, 10, 9);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      bad = 0;
      for (int i = 0; i < 10; i++) if (cls[i] !== 16'd0) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL rst_wait_class_regs: %0d nonzero required 0", bad); end
      checks++; if (bus.fc_ready !== 1'b0) begin failures++; $display("FAIL rst_wait_fc_ready: got %b required 0", bus.fc_ready); end
      checks++; if (bus.res_index !== 4'd0 || bus.res_value !== 16'd0) begin failures++; $display("FAIL rst_wait_result: got %0d/%h required 0/0000", bus.res_index, bus.res_value); end
      rst = 1'b0;
      errs = 0; valids = 0; starts = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (frame_err) errs++;
         if (bus.res_valid) valids++;
         if (get_class_start) starts++;
      end
      checks++; if (errs != 0) begin failures++; $display("FAIL rst_wait_no_frame_err: got %0d required 0", errs); end
      checks++; if (valids != 0 || starts != 0) begin failures++; $display("FAIL rst_wait_quiet: got valid=%0d start=%0d required 0/0", valids, starts); end
      checks++; if (bus.fc_ready !== 1'b1) begin failures++; $display("FAIL rst_wait_fc_ready_after: got %b required 1", bus.fc_ready); end
      gc_en = 1'b1;
      for (int i = 0; i < 10; i++) w[i] = 16'($urandom);
      check_frame("after_rst", w, 1'b0);
   endtask

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation still running at %0t, required completion", $time);
      $fatal(1);
   end

   initial begin
      test_reset();
      test_latency();
      test_equal();
      test_framing();
      test_backpressure();
      test_signed_ranking();
      test_random();
      test_watchdog();
      test_reset_in_wait();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
